// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: drives a req/ack bus, aligns stores and extends loads.
// Latency: at least 3 cycles per memory op (IDLE issue, BUSY until ack or timeout, DONE retire).
// Backpressure: stall is high while the op is issued and in flight, and drops in DONE so the op retires.
module mem_access_unit #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MemToReg,
    input  logic             MemWrite,
    input  logic             LB,
    input  logic             LBU,
    input  logic             LH,
    input  logic             LHU,
    input  logic             SB,
    input  logic             SH,
    input  logic [WIDTH-1:0] Result,
    input  logic [WIDTH-1:0] WriteData,
    input  logic             flush,
    output logic             stall,
    output logic [WIDTH-1:0] load_data,
    output logic             load_valid,
    output logic             misalign,
    output logic             bus_err,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    output logic [3:0]       mem_be,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             mem_req_q, mem_req_d;
    logic             mem_we_q, mem_we_d;
    logic [WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]       mem_be_q, mem_be_d;
    logic [WIDTH-1:0] load_data_q, load_data_d;
    logic             load_valid_q, load_valid_d;
    logic             bus_err_q, bus_err_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             kill_q, kill_d;
    logic             is_load_q, is_load_d;
    logic             ld_byte_q, ld_byte_d;
    logic             ld_half_q, ld_half_d;
    logic             ld_sign_q, ld_sign_d;
    logic [1:0]       lo_q, lo_d;

    logic             is_store;
    logic             acc_byte;
    logic             acc_half;
    logic             acc_word;
    logic             op;
    logic             addr_mis;
    logic             issue;
    logic             kill_now;
    logic [7:0]       byte_v;
    logic [15:0]      half_v;
    logic [WIDTH-1:0] ext_data;
    logic [WIDTH-1:0] st_wdata;
    logic [3:0]       st_be;

    // Decode access size and alignment; a store wins when both controls are set
    always_comb begin
        is_store = MemWrite;
        acc_byte = is_store ? SB : (LB | LBU);
        acc_half = is_store ? (SH & ~SB) : ((LH | LHU) & ~(LB | LBU));
        acc_word = ~acc_byte & ~acc_half;
        op       = (MemToReg | MemWrite) & ~flush;
        addr_mis = (acc_half & Result[0]) | (acc_word & (Result[1:0] != 2'b00));
        issue    = (state_q == S_IDLE) & op & ~addr_mis;
        misalign = (state_q == S_IDLE) & op & addr_mis;
        stall    = issue | (state_q == S_BUSY);
    end

    // Store lane steering: replicate the low bytes/halves and enable only the addressed lanes
    always_comb begin
        st_wdata = WriteData;
        st_be    = 4'b1111;
        if (acc_byte) begin
            st_wdata = {4{WriteData[7:0]}};
            st_be    = 4'b0001 << Result[1:0];
        end else if (acc_half) begin
            st_wdata = {2{WriteData[15:0]}};
            st_be    = Result[1] ? 4'b1100 : 4'b0011;
        end
    end

    // Load extraction from the lane captured at issue time
    always_comb begin
        byte_v   = mem_rdata[{lo_q, 3'b000} +: 8];
        half_v   = lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        ext_data = mem_rdata;
        if (ld_byte_q) begin
            ext_data = {{(WIDTH-8){ld_sign_q & byte_v[7]}}, byte_v};
        end else if (ld_half_q) begin
            ext_data = {{(WIDTH-16){ld_sign_q & half_v[15]}}, half_v};
        end
    end

    // Next-state logic: issue in IDLE, wait for ack or timeout in BUSY, retire in DONE
    always_comb begin
        state_d      = state_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_be_d     = mem_be_q;
        load_data_d  = load_data_q;
        load_valid_d = 1'b0;
        bus_err_d    = 1'b0;
        cnt_d        = cnt_q;
        kill_d       = kill_q;
        is_load_d    = is_load_q;
        ld_byte_d    = ld_byte_q;
        ld_half_d    = ld_half_q;
        ld_sign_d    = ld_sign_q;
        lo_d         = lo_q;
        kill_now     = kill_q | flush;
        case (state_q)
            S_IDLE: begin
                kill_d = 1'b0;
                cnt_d  = '0;
                if (issue) begin
                    state_d     = S_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = MemWrite;
                    mem_addr_d  = {Result[WIDTH-1:2], 2'b00};
                    mem_wdata_d = st_wdata;
                    mem_be_d    = st_be;
                    is_load_d   = ~is_store;
                    ld_byte_d   = acc_byte;
                    ld_half_d   = acc_half;
                    ld_sign_d   = acc_byte ? LB : LH;
                    lo_d        = Result[1:0];
                end
            end
            S_BUSY: begin
                cnt_d  = cnt_q + 1'b1;
                kill_d = kill_now;
                if (mem_ack) begin
                    state_d      = S_DONE;
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    load_valid_d = is_load_q & ~kill_now;
                    if (is_load_q) begin
                        load_data_d = ext_data;
                    end
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d   = S_DONE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    bus_err_d = ~kill_now;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_be_q     <= 4'b0000;
            load_data_q  <= '0;
            load_valid_q <= 1'b0;
            bus_err_q    <= 1'b0;
            cnt_q        <= '0;
            kill_q       <= 1'b0;
            is_load_q    <= 1'b0;
            ld_byte_q    <= 1'b0;
            ld_half_q    <= 1'b0;
            ld_sign_q    <= 1'b0;
            lo_q         <= 2'b00;
        end else begin
            state_q      <= state_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_be_q     <= mem_be_d;
            load_data_q  <= load_data_d;
            load_valid_q <= load_valid_d;
            bus_err_q    <= bus_err_d;
            cnt_q        <= cnt_d;
            kill_q       <= kill_d;
            is_load_q    <= is_load_d;
            ld_byte_q    <= ld_byte_d;
            ld_half_q    <= ld_half_d;
            ld_sign_q    <= ld_sign_d;
            lo_q         <= lo_d;
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_be     = mem_be_q;
    assign load_data  = load_data_q;
    assign load_valid = load_valid_q;
    assign bus_err    = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized and directed bench for mem_access_unit against a transaction-level reference model.
// Latency: one transaction at a time, IDLE/BUSY.../DONE checked cycle by cycle.
// Backpressure: mem_ack is driven by the bench at a chosen BUSY cycle, or never for timeouts.
module tb_mem_access_unit;

    localparam int TO = 16;

    // access kinds used by the reference model
    localparam int K_LW = 0, K_LB = 1, K_LBU = 2, K_LH = 3, K_LHU = 4, K_SW = 5, K_SB = 6, K_SH = 7;

    logic        clk = 1'b0;
    logic        rst;
    logic        MemToReg, MemWrite, LB, LBU, LH, LHU, SB, SH;
    logic [31:0] Result, WriteData;
    logic        flush;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid, misalign, bus_err;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int n_chk  = 0;
    int n_fail = 0;

    mem_access_unit #(.WIDTH(32), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .MemToReg(MemToReg), .MemWrite(MemWrite),
        .LB(LB), .LBU(LBU), .LH(LH), .LHU(LHU), .SB(SB), .SH(SH),
        .Result(Result), .WriteData(WriteData), .flush(flush),
        .stall(stall), .load_data(load_data), .load_valid(load_valid),
        .misalign(misalign), .bus_err(bus_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int acc_size(input int k);
        case (k)
            K_LB, K_LBU, K_SB: return 1;
            K_LH, K_LHU, K_SH: return 2;
            default:           return 4;
        endcase
    endfunction

    function automatic bit is_store(input int k);
        return k >= K_SW;
    endfunction

    function automatic bit model_mis(input int k, input logic [31:0] a);
        return (a % acc_size(k)) != 0;
    endfunction

    function automatic logic [3:0] model_be(input int k, input logic [31:0] a);
        int lane = a % 4;
        if (acc_size(k) == 1) return 4'(1 << lane);
        if (acc_size(k) == 2) return 4'(3 << lane);
        return 4'hF;
    endfunction

    function automatic logic [31:0] model_wdata(input int k, input logic [31:0] wd);
        if (acc_size(k) == 1) return (wd & 32'hFF) * 32'h0101_0101;
        if (acc_size(k) == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [31:0] model_load(input int k, input logic [31:0] a, input logic [31:0] rd);
        int          sz   = acc_size(k);
        logic [31:0] mask;
        logic [31:0] v;
        bit          sgn  = (k == K_LB) || (k == K_LH);
        if (sz == 4) return rd;
        mask = (sz == 1) ? 32'hFF : 32'hFFFF;
        v    = (rd >> (8 * (a % 4))) & mask;
        if (sgn && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic drive_ctrl(input int k, input logic [31:0] a, input logic [31:0] wd);
        MemToReg  = !is_store(k);
        MemWrite  = is_store(k);
        LB        = (k == K_LB);
        LBU       = (k == K_LBU);
        LH        = (k == K_LH);
        LHU       = (k == K_LHU);
        SB        = (k == K_SB);
        SH        = (k == K_SH);
        Result    = a;
        WriteData = wd;
    endtask

    task automatic clear_ctrl();
        {MemToReg, MemWrite, LB, LBU, LH, LHU, SB, SH} = '0;
        flush = 1'b0;
    endtask

    // One memory op. ack_at = BUSY cycle carrying mem_ack (0 = never); fl = flush in first BUSY cycle.
    task automatic run_access(input int k, input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] rd, input int ack_at, input bit fl);
        bit acked = 1'b0;
        bit mis   = model_mis(k, a);
        bit ld    = !is_store(k);
        @(posedge clk); #1;
        drive_ctrl(k, a, wd);
        mem_ack = 1'b0;
        @(negedge clk);
        check_eq("idle_misalign", 32'(misalign), 32'(mis));
        check_eq("idle_stall", 32'(stall), 32'(!mis));
        check_eq("idle_req", 32'(mem_req), 32'd0);
        if (mis) begin
            clear_ctrl();
            return;
        end
        for (int c = 1; c <= TO; c++) begin
            @(posedge clk); #1;
            flush     = fl && (c == 1);
            mem_ack   = (c == ack_at);
            mem_rdata = (c == ack_at) ? rd : $urandom;
            @(negedge clk);
            check_eq("busy_req", 32'(mem_req), 32'd1);
            check_eq("busy_stall", 32'(stall), 32'd1);
            if (c == 1) begin
                check_eq("busy_addr", mem_addr, a & 32'hFFFF_FFFC);
                check_eq("busy_be", 32'(mem_be), 32'(model_be(k, a)));
                check_eq("busy_we", 32'(mem_we), 32'(is_store(k)));
                if (is_store(k)) check_eq("busy_wdata", mem_wdata, model_wdata(k, wd));
            end
            if (c == ack_at) begin
                acked = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        flush   = 1'b0;
        mem_ack = $urandom_range(0, 1);   // must be ignored outside BUSY
        @(negedge clk);
        check_eq("done_stall", 32'(stall), 32'd0);
        check_eq("done_req", 32'(mem_req), 32'd0);
        check_eq("done_valid", 32'(load_valid), 32'(ld && acked && !fl));
        check_eq("done_buserr", 32'(bus_err), 32'(!acked && !fl));
        if (ld && acked && !fl) check_eq("done_data", load_data, model_load(k, a, rd));
        clear_ctrl();
        mem_ack = 1'b0;
    endtask

    initial begin
        rst       = 1'b0;
        clear_ctrl();
        Result    = '0;
        WriteData = '0;
        mem_rdata = '0;
        mem_ack   = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_req", 32'(mem_req), 32'd0);
        check_eq("rst_stall", 32'(stall), 32'd0);
        check_eq("rst_be", 32'(mem_be), 32'd0);
        check_eq("rst_addr", mem_addr, 32'd0);
        check_eq("rst_ldata", load_data, 32'd0);
        check_eq("rst_valid", 32'(load_valid), 32'd0);
        check_eq("rst_buserr", 32'(bus_err), 32'd0);
        rst = 1'b1;

        // directed cases
        run_access(K_SW,  32'h1004, 32'hDEAD_BEEF, 32'h0, 1, 1'b0);
        run_access(K_LB,  32'h2003, 32'h0, 32'h8011_2233, 1, 1'b0);
        run_access(K_LBU, 32'h2003, 32'h0, 32'h8011_2233, 2, 1'b0);
        run_access(K_SH,  32'h0010, 32'h0000_ABCD, 32'h0, 1, 1'b0);
        run_access(K_LH,  32'h0012, 32'h0, 32'h9ABC_0000, 1, 1'b0);
        run_access(K_LW,  32'h0002, 32'h0, 32'h0, 1, 1'b0);
        run_access(K_LW,  32'h0040, 32'h0, 32'h0, 0, 1'b0);
        run_access(K_LW,  32'h0044, 32'h0, 32'h1234_5678, 2, 1'b1);
        run_access(K_SB,  32'h0031, 32'h0000_00A5, 32'h0, 1, 1'b0);
        run_access(K_LHU, 32'h0016, 32'h0, 32'h8765_4321, 3, 1'b0);

        // reset while BUSY abandons the transaction
        @(posedge clk); #1;
        drive_ctrl(K_LW, 32'h0080, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        clear_ctrl();
        @(negedge clk);
        check_eq("midrst_busy_req", 32'(mem_req), 32'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_eq("midrst_req", 32'(mem_req), 32'd0);
        check_eq("midrst_stall", 32'(stall), 32'd0);

        // randomized ops
        for (int i = 0; i < 60; i++) begin
            int          k   = $urandom_range(0, 7);
            logic [31:0] a   = $urandom & 32'h0000_FFFF;
            int          ack = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 4);
            bit          fl  = ($urandom_range(0, 7) == 0);
            run_access(k, a, $urandom, $urandom, ack, fl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage memory access unit, directly downstream of the EX/MEM pipeline register.
- Consumes the registered memory controls, ALU result (address) and store data.
- Drives a request/acknowledge data-memory bus and stalls the pipeline while a transaction is in flight.
- Returns aligned, extended load data and flags misaligned accesses and bus timeouts for the CAUSE/EPC path.

Parameters:
WIDTH, 32, data/address width
TIMEOUT, 16, max BUSY cycles waiting for ack before bus_err (>=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-low
MemToReg  in  1  load in MEM stage
MemWrite  in  1  store in MEM stage
LB, LBU, LH, LHU  in  1 each  load size/sign; none set with MemToReg = word
SB, SH  in  1 each  store size; none set with MemWrite = word
Result  in  WIDTH  byte address
WriteData  in  WIDTH  store data (unaligned, low bits)
flush  in  1  kill current MEM instruction
stall  out  1  hold IF..EX/MEM enables low
load_data  out  WIDTH  extended load result, valid when load_valid
load_valid  out  1  one-cycle pulse, load completed
misalign  out  1  misaligned access, combinational, IDLE only
bus_err  out  1  one-cycle pulse, ack timeout
mem_req  out  1  bus request (registered)
mem_we  out  1  write strobe (registered)
mem_addr  out  WIDTH  word address, Result with [1:0]=0
mem_wdata  out  WIDTH  lane-replicated store data
mem_be  out  4  byte enables
mem_rdata  in  WIDTH  read data, valid with mem_ack
mem_ack  in  1  transaction complete

Behaviour:
- Reset (rst==0 at clk edge): state IDLE; mem_req, mem_we, mem_addr, mem_wdata, mem_be, load_data, load_valid, bus_err, timeout counter all 0. Abandons any in-flight transaction.
- op = (MemToReg|MemWrite) & ~flush.
- Misalignment, evaluated only in IDLE:
  - half (LH/LHU/SH) with Result[0]=1, or word with Result[1:0]!=0 -> misalign=1.
  - No request is issued, stall=0.
  - A byte access is never misaligned.
- IDLE:
  - op & ~misalign -> register mem_req=1, mem_we=MemWrite, mem_addr, mem_wdata, mem_be; go BUSY.
  - stall=1 combinationally in that same cycle.
  - Otherwise stall=0 (pass-through).
- BUSY:
  - stall=1; bus outputs held stable; counter increments each cycle.
  - mem_ack=1 -> mem_req=0, mem_we=0; go DONE.
  - On a load, load_data <= extract(mem_rdata).
  - Counter reaching TIMEOUT with no ack -> mem_req=0, bus_err pulse next cycle; go DONE; load_valid stays 0.
- DONE: stall=0, so the pipeline advances at the end of this cycle; load_valid=1 if a load completed without error; always go IDLE. Minimum memory-op occupancy is 3 cycles (IDLE, BUSY, DONE) with ack in the first BUSY cycle.
- flush: in IDLE, suppresses the request. In BUSY, the transaction still completes (bus protocol never aborted), but load_valid and bus_err are suppressed in DONE. The flush is latched in a kill flag cleared on IDLE.
- Store lanes:
  - SB: be = 1<<Result[1:0]; wdata = {4{WriteData[7:0]}}.
  - SH: be = Result[1] ? 1100 : 0011; wdata = {2{WriteData[15:0]}}.
  - Word: be=1111; wdata=WriteData.
- Load extract:
  - byte = rdata lane Result[1:0]; LB sign-extend, LBU zero-extend.
  - half = Result[1] ? rdata[31:16] : rdata[15:0]; LH sign-extend, LHU zero-extend.
  - Word = rdata.
- mem_ack outside BUSY is ignored.
- If MemToReg and MemWrite are both set, the access is a store.

Test Plan:
1. SW Result=0x1004, WriteData=0xDEADBEEF, ack on 1st BUSY cycle -> mem_req high 1 cycle, mem_addr=0x1004, be=1111, we=1; stall high 2 cycles then low in DONE.
2. LB Result=0x2003, rdata=0x80112233 -> load_data=0xFFFFFF80, load_valid pulse; same with LBU -> 0x00000080.
3. SH Result=0x10, WriteData=0x0000ABCD -> be=0011, wdata=0xABCDABCD. Then LH Result=0x12, rdata=0x9ABC0000 -> load_data=0xFFFF9ABC.
4. LW Result=0x2 -> misalign=1, mem_req stays 0, stall=0.
5. LW with mem_ack never asserted, TIMEOUT=16 -> mem_req drops after 16 BUSY cycles, bus_err pulse, load_valid=0, stall released.
6. rst low while BUSY -> next edge mem_req=0, state IDLE, stall=0. flush in BUSY -> load_valid stays 0 after ack.
